// File: rtl/totlen_fifo.sv
// Store-and-forward AXI-Stream packet buffer that publishes each packet's byte length on a side stream.
// Define TOTLEN_DROP_EN to discard packets that overflow the data FIFO (counted on drop_count).
module totlen_fifo #(
    parameter int KEEP_W    = 1,
    parameter int DEPTH     = 2048,
    parameter int LEN_DEPTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    input  logic [8*KEEP_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0]   s_tkeep,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [8*KEEP_W-1:0] m_tdata,
    output logic [KEEP_W-1:0]   m_tkeep,
    output logic                length_tvalid,
    input  logic                length_tready,
    output logic [15:0]         length_tdata
`ifdef TOTLEN_DROP_EN
    ,
    output logic [15:0]         drop_count
`endif
);
    localparam int DW  = 8 * KEEP_W;
    localparam int WW  = DW + KEEP_W + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam logic [AW:0]  D_FULL = (AW+1)'(DEPTH);
    localparam logic [LAW:0] L_FULL = (LAW+1)'(LEN_DEPTH);
    localparam logic [AW:0]  D_ONE  = (AW+1)'(1);
    localparam logic [LAW:0] L_ONE  = (LAW+1)'(1);

    function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) n = n + 16'(k[i]);
        return n;
    endfunction

    logic [WW-1:0] data_mem [DEPTH];
    logic [15:0]   len_mem [LEN_DEPTH];

    logic [AW:0]   wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [LAW:0]  lwptr_q, lwptr_d, lrptr_q, lrptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic          data_full, len_full, accept, wr_en, len_push;
    logic [15:0]   beat_bytes, len_val, len_word;
    logic [WW-1:0] rd_word;
`ifdef TOTLEN_DROP_EN
    logic          dropping_q, dropping_d, drop_beat;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        // Pointers carry one extra bit so full and empty are distinguishable.
        data_full  = (wptr_q - rptr_q) == D_FULL;
        len_full   = (lwptr_q - lrptr_q) == L_FULL;
        beat_bytes = popcount(s_tkeep);
`ifdef TOTLEN_DROP_EN
        s_tready   = rdy_q && !len_full;
        accept     = s_tvalid && s_tready;
        drop_beat  = accept && (dropping_q || data_full);
        wr_en      = accept && !drop_beat;
`else
        s_tready   = rdy_q && !len_full && !data_full;
        accept     = s_tvalid && s_tready;
        wr_en      = accept;
`endif
        rdy_d    = 1'b1;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        cnt_d    = cnt_q;
        len_push = 1'b0;
        len_val  = cnt_q + beat_bytes;
        if (wr_en) begin
            wptr_d = wptr_q + D_ONE;
            if (s_tlast) begin
                cptr_d   = wptr_q + D_ONE;
                len_push = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = len_val;
            end
        end
`ifdef TOTLEN_DROP_EN
        dropping_d = dropping_q;
        drop_cnt_d = drop_cnt_q;
        // An overflowing packet is abandoned on its first rejected beat; the rest is swallowed.
        if (drop_beat) begin
            wptr_d     = cptr_q;
            cnt_d      = '0;
            dropping_d = !s_tlast;
            if (s_tlast && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        drop_count = drop_cnt_q;
`endif
        m_tvalid = rptr_q != cptr_q;
        rd_word  = data_mem[rptr_q[AW-1:0]];
        rptr_d   = (m_tvalid && m_tready) ? rptr_q + D_ONE : rptr_q;
        m_tdata  = m_tvalid ? rd_word[DW-1:0] : '0;
        m_tkeep  = m_tvalid ? rd_word[DW +: KEEP_W] : '0;
        m_tlast  = m_tvalid && rd_word[WW-1];

        length_tvalid = lwptr_q != lrptr_q;
        len_word      = len_mem[lrptr_q[LAW-1:0]];
        length_tdata  = length_tvalid ? len_word : '0;
        lrptr_d       = (length_tvalid && length_tready) ? lrptr_q + L_ONE : lrptr_q;
        lwptr_d       = len_push ? lwptr_q + L_ONE : lwptr_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q     <= '0;
            cptr_q     <= '0;
            rptr_q     <= '0;
            lwptr_q    <= '0;
            lrptr_q    <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
`ifdef TOTLEN_DROP_EN
            dropping_q <= 1'b0;
            drop_cnt_q <= '0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            cptr_q     <= cptr_d;
            rptr_q     <= rptr_d;
            lwptr_q    <= lwptr_d;
            lrptr_q    <= lrptr_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
`ifdef TOTLEN_DROP_EN
            dropping_q <= dropping_d;
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    // Storage is not reset; visibility is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wptr_q[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        if (len_push) len_mem[lwptr_q[LAW-1:0]] <= len_val;
    end
endmodule

// File: tb/tb_totlen_fifo.sv
// Self-checking bench for totlen_fifo: directed cases plus randomized back-pressure vs. a packet-level model.
module tb_totlen_fifo;
    localparam int KW = 4;
    localparam int D  = 16;
    localparam int LD = 4;
`ifdef TOTLEN_DROP_EN
    localparam int MAXB = 6;
`else
    localparam int MAXB = 12;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tready;
    logic        m_tvalid, m_tlast, length_tvalid;
    logic        m_tready = 1'b0, length_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic [15:0] length_tdata;
`ifdef TOTLEN_DROP_EN
    logic [15:0] drop_count;
`endif

    logic m_fix = 1'b0, l_fix = 1'b0, m_rnd = 1'b0, l_rnd = 1'b0;
    int   checks = 0, errors = 0;
    beat_t       exp_q[$];
    logic [15:0] len_q[$];
    logic        hold_m = 1'b0, hold_l = 1'b0;
    logic [36:0] hold_mv;
    logic [15:0] hold_lv;
    int          bc = 0;

    totlen_fifo #(.KEEP_W(KW), .DEPTH(D), .LEN_DEPTH(LD)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .length_tvalid(length_tvalid), .length_tready(length_tready),
        .length_tdata(length_tdata)
`ifdef TOTLEN_DROP_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_tready      = m_rnd ? ($urandom_range(0, 3) != 0) : m_fix;
        length_tready = l_rnd ? ($urandom_range(0, 2) != 0) : l_fix;
    end

    always @(negedge clk) begin
        beat_t b;
        if (resetn) begin
            if (hold_m) begin
                check("m_valid_held", 64'(m_tvalid), 64'd1);
                check("m_payload_stable", 64'({m_tlast, m_tkeep, m_tdata}), 64'(hold_mv));
            end
            if (hold_l) begin
                check("len_valid_held", 64'(length_tvalid), 64'd1);
                check("len_stable", 64'(length_tdata), 64'(hold_lv));
            end
            hold_m  = m_tvalid && !m_tready;
            hold_mv = {m_tlast, m_tkeep, m_tdata};
            hold_l  = length_tvalid && !length_tready;
            hold_lv = length_tdata;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("m_unexpected_beat", 64'd1, 64'd0);
                else begin
                    b = exp_q.pop_front();
                    check("m_tdata", 64'(m_tdata), 64'(b.d));
                    check("m_tkeep", 64'(m_tkeep), 64'(b.k));
                    check("m_tlast", 64'(m_tlast), 64'(b.l));
                end
            end
            if (length_tvalid && length_tready) begin
                if (len_q.size() == 0) check("len_unexpected", 64'd1, 64'd0);
                else check("length_tdata", 64'(length_tdata), 64'(len_q.pop_front()));
            end
        end else begin
            hold_m = 1'b0;
            hold_l = 1'b0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output logic ok);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (s_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!ok) check("s_tready_timeout", 64'd0, 64'd1);
    endtask

    // Beats are only expected downstream once the whole packet has been accepted.
    task automatic send_pkt(input int nb, input logic [3:0] lastk, input bit incr, input bit dropped);
        beat_t pend[$];
        beat_t b;
        int bytes = 0;
        logic ok;
        for (int i = 0; i < nb; i++) begin
            b.l = (i == nb - 1);
            b.k = b.l ? lastk : 4'hF;
            b.d = incr ? {8'(bc + 3), 8'(bc + 2), 8'(bc + 1), 8'(bc)} : $urandom;
            bc += 4;
            send_beat(b.d, b.k, b.l, ok);
            if (!ok) return;
            pend.push_back(b);
            bytes += $countones(b.k);
        end
        if (!dropped) begin
            foreach (pend[i]) exp_q.push_back(pend[i]);
            len_q.push_back(16'(bytes));
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("drain_in_time", 64'(t < 5000), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("m_idle_after_drain", 64'(m_tvalid), 64'd0);
        check("len_idle_after_drain", 64'(length_tvalid), 64'd0);
    endtask

    function automatic logic [3:0] rand_lastk();
        int n = $urandom_range(0, 4);
        return 4'((1 << n) - 1);
    endfunction

    initial begin
        logic ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_len_tvalid", 64'(length_tvalid), 64'd0);
        check("rst_len_tdata", 64'(length_tdata), 64'd0);
`ifdef TOTLEN_DROP_EN
        check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s_tready_after_reset", 64'(s_tready), 64'd1);

        // Single-beat packet with consumers stalled: both streams valid the next cycle.
        @(posedge clk); #1;
        send_pkt(1, 4'hF, 1, 0);
        @(negedge clk);
        check("m_tvalid_next_cycle", 64'(m_tvalid), 64'd1);
        check("len_tvalid_next_cycle", 64'(length_tvalid), 64'd1);
        check("len_first_value", 64'(length_tdata), 64'd4);
        check("m_tlast_single", 64'(m_tlast), 64'd1);
        m_fix = 1'b1; l_fix = 1'b1;
        drain();

        @(posedge clk); #1;
        send_pkt(1, 4'hF, 1, 0);
        send_pkt(2, 4'h1, 1, 0);
        send_pkt(2, 4'h3, 1, 0);
        send_pkt(3, 4'h3, 1, 0);
        send_pkt(1, 4'h0, 1, 0);
        drain();

`ifdef TOTLEN_DROP_EN
        m_fix = 1'b0;
        @(posedge clk); #1;
        send_pkt(20, 4'hF, 0, 1);
        send_pkt(4, 4'hF, 0, 0);
        @(negedge clk);
        check("drop_count_one", 64'(drop_count), 64'd1);
        m_fix = 1'b1;
        drain();
`endif

        // Length FIFO full must block input even though data space remains.
        l_fix = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < LD; i++) send_pkt(1, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("len_full_blocks_input", 64'(s_tready), 64'd0);
        end
        l_fix = 1'b1;
        @(posedge clk); #1;
        send_pkt(1, 4'h7, 0, 0);
        drain();

        // Reset mid-packet with one committed packet still buffered.
        m_fix = 1'b0; l_fix = 1'b0;
        @(posedge clk); #1;
        send_pkt(2, 4'hF, 0, 0);
        send_beat($urandom, 4'hF, 1'b0, ok);
        send_beat($urandom, 4'hF, 1'b0, ok);
        resetn = 1'b0;
        exp_q.delete();
        len_q.delete();
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_len_tvalid", 64'(length_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        m_fix = 1'b1; l_fix = 1'b1;
        @(posedge clk); #1;
        send_pkt(3, 4'h7, 0, 0);
        drain();

        // Random packets under random back-pressure on both output streams.
`ifndef TOTLEN_DROP_EN
        m_rnd = 1'b1;
`endif
        l_rnd = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 1000; n++) begin
            send_pkt($urandom_range(1, MAXB), rand_lastk(), 0, 0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/totlen_fifo.md
# totlen_fifo

Parametrised store-and-forward AXI-Stream packet buffer that measures each packet's total byte length and publishes it on a separate length stream before any downstream framing logic consumes the payload. Sits between the MAC/UDP payload source and the header builders in the UDP stack, so IP/UDP total-length fields can be written before payload bytes are emitted. Generalises the single-byte-lane length counter: multi-byte lanes with `tkeep`, multiple buffered packets, and optional oversize drop.

## Interface
Parameters:
- `KEEP_W`, 1, byte lanes per beat; data width is `8*KEEP_W`.
- `DEPTH`, 2048, data FIFO depth in beats; power of 2; `DEPTH*KEEP_W <= 65535`.
- `LEN_DEPTH`, 16, length FIFO depth in packets; power of 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `s_tvalid`, `s_tready`, `s_tlast`  in/out/in  1  input stream handshake/frame end.
- `s_tdata`  in  8*KEEP_W  input data, byte 0 in bits [7:0].
- `s_tkeep`  in  KEEP_W  byte enables; all-ones except on the `tlast` beat, where they are contiguous from bit 0.
- `m_tvalid`, `m_tready`, `m_tlast`  out/in/out  1  output stream.
- `m_tdata`  out  8*KEEP_W  output data.
- `m_tkeep`  out  KEEP_W  output byte enables, replayed unchanged.
- `length_tvalid`, `length_tready`  out/in  1  length stream handshake.
- `length_tdata`  out  16  packet byte count.
- `drop_count`  out  16  dropped-packet counter (present only with `TOTLEN_DROP_EN`).

## Operation
- Write side: data FIFO with working write pointer `wptr` and committed pointer `cptr`. Accepted beats write at `wptr`. A byte counter adds `popcount(s_tkeep)` per accepted beat.
- On the accepted `tlast` beat: `cptr <= wptr+1`, push final byte count to length FIFO, clear counter.
- Read side sees only committed beats; `m_tvalid = (rptr != cptr)`. Uncommitted beats are never visible.
- Length and data streams are independent; consumer may pop length before, during or after the packet data. Nth length entry always belongs to Nth packet.
- `s_tready = !data_full && !len_full`. `data_full` is evaluated against `rptr` (free space), `len_full` at `LEN_DEPTH` entries.
- Length FIFO full blocks all input beats, including mid-packet.
- Zero-length packets are impossible: one beat minimum; a `tlast` beat with `tkeep` 0 yields length 0 and one output beat with `m_tkeep` 0.
- Simultaneous commit and read of the last committed beat: `m_tvalid` stays high if the new commit advances `cptr`.
- Counter arithmetic: 16-bit, no wrap possible under the `DEPTH*KEEP_W` constraint.

## Timing
- Reset (`resetn`=0 at an edge): all pointers, counters, FIFOs clear; `s_tready`, `m_tvalid`, `m_tlast`, `length_tvalid`=0; `m_tdata`, `m_tkeep`, `length_tdata`, `drop_count`=0. `s_tready` rises on the first cycle after reset is released.
- Reset mid-packet discards partial and buffered packets; no length is emitted for them.
- Tlast accepted at edge N: `length_tvalid` and `m_tvalid` (for an otherwise empty buffer) both high in cycle N+1.
- Output is first-word-fall-through; sustained throughput one beat/cycle on both sides.
- AXI rules: valid never drops without ready; data stable while valid && !ready.

## Configuration
- `TOTLEN_DROP_EN` defined: if a beat arrives while `data_full`, `s_tready` stays 1 for the data side. The remainder of the packet through `tlast` is discarded; `wptr` rewinds to `cptr`, no length is pushed, and `drop_count` increments (saturating at 0xFFFF) at the discarded `tlast`. Length-FIFO full still deasserts `s_tready`.
- Not defined: `s_tready` deasserts on `data_full`. Packets longer than `DEPTH` beats are unsupported (deadlock), and `drop_count` is absent.

## Test plan
- `KEEP_W`=1: packets of 4,5,6 bytes, `m_tready`/`length_tready`=1 -> lengths 4,5,6, data bytes incrementing, `m_tlast` on beat 4,5,6.
- `KEEP_W`=4: 3 beats, last `tkeep`=0x3 -> `length_tdata`=10, `m_tkeep` 0xF,0xF,0x3.
- `length_tready`=0: push `LEN_DEPTH`+1 one-beat packets -> `s_tready` low on beat `LEN_DEPTH`+1 until one length is popped.
- `TOTLEN_DROP_EN`, `DEPTH`=16, `m_tready`=0: 20-beat packet then a 4-beat packet -> `drop_count`=1, only length 4 emitted, only the 4 beats output.
- Assert `resetn`=0 for one cycle mid-packet after one committed packet -> all valids 0 next cycle, and the next packet reports a correct length.
- Random `m_tready`/`length_tready` back-pressure, 1000 packets -> output matches scoreboard, and lengths match byte counts.
